reflet_uart_rx_fifo: RTL and testbench
======================================

# reflet_uart_rx_fifo

Buffered UART receiver feeding the serial-input side of the Reflet 8-bit microcontroller. It oversamples the `rx` pin, validates start and stop bits, and assembles 8N1 frames (optionally 8E1/8O1). Received bytes go into a small first-word-fall-through FIFO, which the controller's UART peripheral drains through a single-cycle read strobe. Framing and overflow conditions are reported through sticky flags.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Must be ≥ 4.
- `FIFO_DEPTH`, default 4: number of bytes buffered. Must be a power of 2, ≥ 2.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Used only when `REFLET_UART_RX_PARITY_EN` is defined.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx` in 1: serial input, idle high. Asynchronous to `clk`.
- `rd_en` in 1: pop strobe. Ignored when `data_valid` = 0.
- `err_clr` in 1: clears all sticky error flags.
- `data_out` out 8: FIFO head byte. Valid only while `data_valid` = 1.
- `data_valid` out 1: FIFO not empty.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `frame_err` out 1: sticky. Set when a stop bit is sampled low.
- `overflow` out 1: sticky. Set when a byte is dropped because the FIFO is full.
- `parity_err` out 1: sticky. Present only with `REFLET_UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) before any use.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE. A single counter runs across the states and counts to `CLKS_PER_BIT`-1.
- IDLE: when synchronized `rx` = 0, go to START and clear the counter.
- START: at count `CLKS_PER_BIT/2`-1 (integer division), sample `rx`.
  - `rx` = 1: false start. Return to IDLE with no flag raised.
  - `rx` = 0: go to DATA and reset the counter. All later samples are taken every `CLKS_PER_BIT` cycles from this point.
- DATA: sample 8 bits, LSB first, into a shift register. A 3-bit index counts the bits. After bit 7, go to PARITY if it is compiled in, otherwise STOP.
- STOP, sample = 1:
  - If the byte is good and the FIFO is not full, push it.
  - If the FIFO is full, drop the byte and set `overflow`.
  - Return to IDLE.
- STOP, sample = 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until synchronized `rx` = 1, then go to IDLE. This prevents a break condition from being decoded as a stream of bytes.
- FIFO:
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full = same index with opposite MSB; empty = pointers equal.
  - `data_out` = `mem[rd_ptr]`, combinational (FWFT).
- Push and pop in the same cycle:
  - When full, the pop is honoured and the push is accepted. No overflow is raised.
  - When empty, only the push takes effect.
- `rd_en` while empty: no effect. Pointers are unchanged.
- `err_clr` and a new error in the same cycle: the set wins.
- Reset values:
  - FSM = IDLE; pointers = 0; all flags = 0.
  - `data_valid` = 0, `fifo_full` = 0.
  - `data_out` is undefined while empty. Memory is not reset.
- `reset` mid-frame: the partial byte is lost and the FIFO is emptied. After reset, the next falling edge is treated as a new start bit.

## Timing
- Latency from the `rx` falling edge at the pin to `data_valid` = 1 is 2 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT` + 1 cycles (+`CLKS_PER_BIT` with parity).
- The push registers at the stop-sample edge. `data_valid` rises on the following cycle.
- A pop takes effect at the `rd_en` edge. The next head byte is on `data_out` in the following cycle.
- Flags update one cycle after the sampling edge that causes them.
- Back-to-back frames: a start bit may begin immediately after the stop sample (half a stop bit of margin).

## Configuration
- `REFLET_UART_RX_PARITY_EN` defined:
  - Adds the PARITY state, the `parity_err` port and the `PARITY_ODD` behaviour.
  - Bytes with bad parity are discarded and `parity_err` is set.
  - The stop bit is still checked.
- Not defined: 8N1 only. No PARITY state, no `parity_err` port, and `PARITY_ODD` is unused.

## Structure
- Shared package `reflet_uart_pkg` holds:
  - FSM state encodings, shared with the future TX block.
  - The `CLKS_PER_BIT` validity checks.
- Sub-module `reflet_sync_fifo` (8-bit, `FIFO_DEPTH` deep, FWFT). It is reused by the TX path.
- The top level contains the synchronizer, the FSM and the flag logic.

## Test plan
All cases use `CLKS_PER_BIT` = 16 and `FIFO_DEPTH` = 4.
- Frame 0xA5 (8N1) -> `data_valid` rises at the computed latency, `data_out` = 0xA5. Pulse `rd_en` -> `data_valid` = 0.
- `rx` low for 4 cycles, then high -> no push and no flags.
- Frame 0x3C with stop bit low, `rx` held low for 40 more cycles -> `frame_err` = 1, no push, no byte decoded until `rx` returns high. Then `err_clr` -> `frame_err` = 0.
- Bytes 0x01..0x05 with no reads -> `fifo_full` = 1, `overflow` = 1. Reads return 0x01..0x04, then `data_valid` = 0.
- FIFO full and `rd_en` asserted on the stop-sample cycle of a 5th byte 0x55 -> `overflow` stays 0; reads return 0x02, 0x03, 0x04, 0x55.
- `reset` pulsed during bit 4 of 0xFF -> all outputs return to reset values. A following 0x81 is received correctly. With parity enabled (even), 0x07 sent with parity bit 0 -> `parity_err` = 1, no push.

Source files
------------

// File: rtl/reflet_uart_pkg.sv
// Definitions shared by the Reflet UART RX and TX blocks: FSM state encoding
// and the parameter sanity checks applied at elaboration.
package reflet_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_t;

    localparam int MIN_CLKS_PER_BIT = 4;

    function automatic bit clks_per_bit_ok(input int clks_per_bit);
        return clks_per_bit >= MIN_CLKS_PER_BIT;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/reflet_sync_fifo.sv
// First-word-fall-through synchronous FIFO used by both Reflet UART paths.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module reflet_sync_fifo
    import reflet_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("reflet_sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/reflet_uart_rx_fifo.sv
// Buffered UART receiver (8N1) for the Reflet MCU. Define REFLET_UART_RX_PARITY_EN
// to add a parity bit (8E1, or 8O1 with PARITY_ODD=1) and the parity_err flag.
module reflet_uart_rx_fifo
    import reflet_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overflow
`ifdef REFLET_UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    if (!clks_per_bit_ok(CLKS_PER_BIT)) begin : g_bad_clks
        $error("reflet_uart_rx_fifo: CLKS_PER_BIT must be at least 4");
    end

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_p0;
    logic          rx_p1;
    logic          rx_sync;
    logic          bit_tick;
    logic          byte_good;
    logic          push;
    logic          fifo_empty;

    // Synchronizer stage: rx is asynchronous; idle-high reset avoids a false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_sync  = rx_p1;
    assign bit_tick = (cnt == BIT_LAST);

`ifdef REFLET_UART_RX_PARITY_EN
    logic parity_ok;
    logic parity_bad;
    assign parity_bad = ((^shift) ^ rx_sync) != PARITY_ODD[0];
    assign byte_good  = parity_ok;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD[0];
    assign byte_good         = 1'b1;
`endif

    assign push = (state == ST_STOP) && bit_tick && rx_sync && byte_good;

    // Receive FSM and sticky flags: one counter is shared by every timed state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
            parity_ok  <= 1'b1;
            parity_err <= 1'b0;
`endif
        end else begin
            // Clear first so an error raised in the same cycle still sets its flag.
            if (err_clr) begin
                frame_err <= 1'b0;
                overflow  <= 1'b0;
`ifdef REFLET_UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef REFLET_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef REFLET_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt       <= '0;
                        parity_ok <= !parity_bad;
                        if (parity_bad) begin
                            parity_err <= 1'b1;
                        end
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state <= ST_IDLE;
                            if (byte_good && fifo_full && !rd_en) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A held-low line (break) must not be decoded as repeated bytes.
                ST_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_DATA) && bit_tick) begin
            shift <= {rx_sync, shift[7:1]};
        end
    end

    reflet_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (shift),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_reflet_uart_rx_fifo.sv
// Bench for reflet_uart_rx_fifo: directed frames and a randomized frame stream,
// all checked every cycle against a queue-based model of the receiver.
module tb_reflet_uart_rx_fifo;

    localparam int C     = 16;
    localparam int DEPTH = 4;
    localparam int PODD  = 0;
`ifdef REFLET_UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB     = 10 + PAR;
    // From the rx falling edge to the clock edge that stores the byte.
    localparam int T_STOP = 2 + C/2 + (NB-1)*C + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overflow;
`ifdef REFLET_UART_RX_PARITY_EN
    logic       parity_err;
`endif

    reflet_uart_rx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_full  (fifo_full),
        .frame_err  (frame_err),
        .overflow   (overflow)
`ifdef REFLET_UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        int         kind;   // 0 push byte, 1 frame error, 2 parity error
        logic [7:0] d;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         m_ferr, m_ovf, m_perr;
    int         cyc = 0;
    bit         rd_s, err_s;
    int         n_chk = 0;
    int         n_fail = 0;
    int         fstart = 0;
    int         rise_cyc = -1;
    bit         dv_prev = 1'b0;
    bit         done;
    int         n_sent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is always 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        logic [NB-1:0] bits;
        bit            par_bad;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (PAR != 0) bits[9] = par;
        bits[NB-1] = stop;
        par_bad = (PAR != 0) && (par != good_par(d));
        fstart = cyc;
        if (par_bad) evq.push_back('{fstart + T_STOP - C, 2, d});
        if (!stop) evq.push_back('{fstart + T_STOP, 1, d});
        else if (!par_bad) evq.push_back('{fstart + T_STOP, 0, d});
        for (int k = 0; k < NB; k++) begin
            rx = bits[k];
            tick(C);
        end
    endtask

    task automatic read_byte(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, data_valid, 1'b1);
        chk({name, "_data"}, data_out, exp);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rd_s  <= rd_en;
        err_s <= err_clr;
    end

    // Model update for the edge just taken, then compare all outputs.
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (err_s) begin
                m_ferr = 1'b0;
                m_ovf  = 1'b0;
                m_perr = 1'b0;
            end
            if (rd_s && mq.size() > 0) void'(mq.pop_front());
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                case (evq[0].kind)
                    0: if (mq.size() < DEPTH) mq.push_back(evq[0].d); else m_ovf = 1'b1;
                    1: m_ferr = 1'b1;
                    default: m_perr = 1'b1;
                endcase
                void'(evq.pop_front());
            end
        end
        chk("m_data_valid", data_valid, mq.size() != 0);
        chk("m_fifo_full", fifo_full, mq.size() == DEPTH);
        chk("m_frame_err", frame_err, m_ferr);
        chk("m_overflow", overflow, m_ovf);
`ifdef REFLET_UART_RX_PARITY_EN
        chk("m_parity_err", parity_err, m_perr);
`endif
        if (mq.size() > 0) chk("m_data_out", data_out, mq[0]);
        if (data_valid && !dv_prev) rise_cyc = cyc;
        dv_prev = data_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        done    = 1'b0;
        n_sent  = 0;
        tick(3);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick(2);

        // Single frame 0xA5 and its exact latency.
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        tick(2);
        chk("a5_latency", rise_cyc - fstart, (PAR != 0) ? 171 : 155);
        read_byte("a5", 8'hA5);
        chk("a5_empty", data_valid, 1'b0);

        // Short low glitch is a false start.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        chk("glitch_valid", data_valid, 1'b0);
        chk("glitch_ferr", frame_err, 1'b0);

        // Stop bit low with the line held low afterwards.
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        tick(40);
        chk("brk_ferr", frame_err, 1'b1);
        chk("brk_valid", data_valid, 1'b0);
        rx = 1'b1;
        tick(10);
        chk("brk_after_valid", data_valid, 1'b0);
        pulse_clr();
        chk("brk_clr", frame_err, 1'b0);

        // Five bytes, no reads: last one overflows.
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1, good_par(8'(b)));
            tick(2);
        end
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        read_byte("ovf_r1", 8'h01);
        read_byte("ovf_r2", 8'h02);
        read_byte("ovf_r3", 8'h03);
        read_byte("ovf_r4", 8'h04);
        chk("ovf_empty", data_valid, 1'b0);
        pulse_clr();
        chk("ovf_clr", overflow, 1'b0);

        // Full FIFO, pop on the same edge as the fifth push.
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1'b1, good_par(8'(b)));
            tick(2);
        end
        fork
            send_frame(8'h55, 1'b1, good_par(8'h55));
            begin
                repeat (T_STOP - 1) @(posedge clk);
                #1 rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        join
        tick(2);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_full", fifo_full, 1'b1);
        read_byte("pp_r1", 8'h02);
        read_byte("pp_r2", 8'h03);
        read_byte("pp_r3", 8'h04);
        read_byte("pp_r4", 8'h55);
        chk("pp_empty", data_valid, 1'b0);

        // Reset in the middle of a frame with state to clear.
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        rx = 1'b1;
        tick(4);
        rx = 1'b0;
        tick(C);
        rx = 1'b1;
        tick(4*C + C/2);
        reset = 1'b1;
        tick(2);
        chk("mid_rst_valid", data_valid, 1'b0);
        chk("mid_rst_full", fifo_full, 1'b0);
        chk("mid_rst_ferr", frame_err, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick(C);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        tick(2);
        read_byte("post_rst", 8'h81);

`ifdef REFLET_UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        tick(2);
        chk("par_err", parity_err, 1'b1);
        chk("par_valid", data_valid, 1'b0);
        pulse_clr();
        chk("par_clr", parity_err, 1'b0);
`endif

        // Randomized stream with random reads and error clears.
        fork
            begin
                logic [7:0] d;
                logic       stop;
                logic       par;
                int         gap;
                for (int i = 0; i < 30; i++) begin
                    d    = 8'($urandom);
                    stop = ($urandom_range(0, 7) != 0);
                    par  = ($urandom_range(0, 7) == 0) ? ~good_par(d) : good_par(d);
                    gap  = stop ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10));
                    send_frame(d, stop, par);
                    rx = 1'b1;
                    n_sent = i + 1;
                    tick(gap);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rd_en   = ($urandom_range(0, (n_sent < 15) ? 400 : 40) == 0);
                    err_clr = ($urandom_range(0, 499) == 0);
                    tick(1);
                end
                rd_en   = 1'b0;
                err_clr = 1'b0;
            end
        join
        tick(2);
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (data_valid) begin
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
            end
        end
        tick(2);
        chk("drain_empty", data_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
